fifo_sync: RTL and testbench
============================

# fifo_sync

Single-clock, synchronous first-in/first-out buffer with a parameterized depth and data width. It sits between a producer and a consumer in the same clock domain. Writes and reads are controlled by enables, and full/empty status flags report occupancy. Read data is registered.

## Interface
- `DEPTH`, default 8: number of storage entries; any integer ≥ 2, not required to be a power of two.
- `DWIDTH`, default 16: data word width in bits.
- `clk`  input  1: clock; all logic is on the rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `wr_en`  input  1: write request; `din` is sampled on the same edge.
- `rd_en`  input  1: read request.
- `din`  input  DWIDTH: write data.
- `dout`  output  DWIDTH: registered read data.
- `empty`  output  1: high when occupancy is 0.
- `full`  output  1: high when occupancy equals DEPTH.
- `overflow`  output  1: present only with `FIFO_ERR_FLAGS_EN`.
- `underflow`  output  1: present only with `FIFO_ERR_FLAGS_EN`.

## Operation
- Storage: DEPTH × DWIDTH array, write pointer, read pointer, and an occupancy counter of width $clog2(DEPTH+1).
- Pointers count from 0 to DEPTH-1, then wrap to 0.
- Write accept rule: `wr_en && (!full || rd_en)`.
  - An accepted write stores `din` at the write pointer and advances the write pointer.
- Read accept rule: `rd_en && !empty`.
  - An accepted read loads `mem[rd_ptr]` into `dout` and advances the read pointer.
- Simultaneous accepted read and write: both pointers advance and occupancy is unchanged.
  - When full, a simultaneous read and write is legal: the read frees the slot the write fills.
  - When empty, a simultaneous read and write: the write is accepted, the read is rejected, and occupancy becomes 1.
- Rejected write: no state change, and the data is dropped.
- Rejected read: `dout` holds its previous value.
- Flags are decoded from the occupancy register: `empty` = (count==0), `full` = (count==DEPTH).
- Reset (`rst`=1 at a rising edge) sets:
  - pointers to 0, count to 0;
  - `dout` to 0;
  - `empty` to 1, `full` to 0;
  - error flags to 0.
- Memory contents are not reset.
- Reset takes priority over `wr_en`/`rd_en` in the same cycle. Reset mid-operation discards all stored data.

## Timing
- Write latency:
  - a write accepted at edge N is readable from edge N+1;
  - `empty` deasserts after edge N.
- Read latency: a read accepted at edge N presents its data on `dout` after edge N, stable until the next accepted read or reset.
- `full` asserts after the edge that accepts the DEPTH-th outstanding write. `empty` asserts after the edge that accepts the last read.
- Flags change only on clock edges. They have no combinational path from `wr_en`/`rd_en`.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- Macro `FIFO_ERR_FLAGS_EN`.
- When defined, ports `overflow` and `underflow` exist:
  - `overflow` pulses high for one cycle, after the edge where `wr_en` was rejected (full and no `rd_en`);
  - `underflow` pulses high for one cycle, after the edge where `rd_en` was asserted while empty.
  - Both flags are registered and cleared by reset.
- When undefined, neither port nor its logic exists. Rejected operations are silently ignored; all other behaviour is identical.

## Test plan
- Reset, then idle 1 cycle → `empty`=1, `full`=0, `dout`=0.
- Write 8 words 0x1111..0x8888 on consecutive cycles, then idle 1 cycle → `full`=1, `empty`=0.
- From full, read 8 times on consecutive cycles → `dout` shows 0x1111..0x8888 in order, one per cycle; then `empty`=1, `full`=0.
- Full FIFO, then `wr_en`=1 with `din`=0xDEAD and `rd_en`=0 → write dropped, contents unchanged, and `overflow` pulses once if enabled. Draining must never yield 0xDEAD.
- Occupancy 4, then simultaneous `wr_en` and `rd_en` for 10 cycles → count stays 4, pointers wrap past 7→0, and data order is preserved.
- Occupancy 5, then `rst`=1 for one edge → `empty`=1, `full`=0, `dout`=0. A subsequent read with `rd_en`=1 is rejected and `dout` stays 0.

Source files
------------

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock synchronous FIFO with registered read data.
//
// Parameters:
//   DEPTH  - number of storage entries (>= 2, any integer)
//   DWIDTH - data word width in bits
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   wr_en, din - write request and write data
//   rd_en      - read request
//   dout       - registered read data, holds until the next accepted read
//   empty      - occupancy == 0
//   full       - occupancy == DEPTH
//   overflow   - one-cycle pulse after a dropped write   (FIFO_ERR_FLAGS_EN only)
//   underflow  - one-cycle pulse after a read while empty (FIFO_ERR_FLAGS_EN only)
// Optional feature macro: FIFO_ERR_FLAGS_EN
module fifo_sync #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [DWIDTH-1:0] din,
   output logic [DWIDTH-1:0] dout,
   output logic              empty,
   output logic              full
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [DWIDTH-1:0] dout_q, dout_d;
   logic              wr_ok, rd_ok;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Flags decode the occupancy register only, never the enables.
   assign empty = (count_q == '0);
   assign full  = (count_q == CntW'(DEPTH));
   assign dout  = dout_q;

   // A write into a full FIFO is allowed when a read frees a slot on the same edge.
   assign wr_ok = wr_en && (!full || rd_en);
   assign rd_ok = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (wr_ok) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (rd_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
         dout_d   = mem[rd_ptr_q];
      end
      unique case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
      end
   end

   // Storage is not reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wr_ptr_q] <= din;
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= wr_en && full && !rd_en;
         underflow_q <= rd_en && empty;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed, table-driven bench for fifo_sync (DEPTH=8, DWIDTH=16),
// plus hand-written sequences for wrap-around, full/empty simultaneous access
// and mid-operation reset.
module tb_fifo_sync;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [15:0] din;
   logic [15:0] dout;
   logic        empty;
   logic        full;
`ifdef FIFO_ERR_FLAGS_EN
   logic        overflow;
   logic        underflow;
`endif

   int n_cmp = 0;
   int n_err = 0;

   fifo_sync #(
      .DEPTH (8),
      .DWIDTH(16)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .wr_en(wr_en),
      .rd_en(rd_en),
      .din  (din),
      .dout (dout),
      .empty(empty),
`ifdef FIFO_ERR_FLAGS_EN
      .overflow (overflow),
      .underflow(underflow),
`endif
      .full (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wr;
      logic        rd;
      logic [15:0] din;
      logic [15:0] dout;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        unf;
   } vec_t;

   localparam int NVec = 21;
   vec_t vecs [NVec];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply inputs, clock one edge, sample 1 ns after it.
   task automatic step(input logic r, input logic w, input logic rd, input logic [15:0] d);
      rst   = r;
      wr_en = w;
      rd_en = rd;
      din   = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string name, input logic [15:0] exp_dout,
                            input logic exp_empty, input logic exp_full);
      chk({name, ".dout"}, dout, exp_dout);
      chk({name, ".empty"}, {15'd0, empty}, {15'd0, exp_empty});
      chk({name, ".full"}, {15'd0, full}, {15'd0, exp_full});
   endtask

   logic [15:0] model [$];
   logic [15:0] exp_word;

   initial begin
      rst   = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;

      // Table: reset, fill 8, idle, dropped write of DEAD, drain 8, read while empty.
      vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 1; k <= 8; k++) begin
         vecs[1 + k] = '{1'b0, 1'b1, 1'b0, 16'(k * 16'h1111), 16'h0000, 1'b0,
                         (k == 8), 1'b0, 1'b0};
      end
      vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 16'hDEAD, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int k = 1; k <= 8; k++) begin
         vecs[11 + k] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'(k * 16'h1111), (k == 8),
                          1'b0, 1'b0, 1'b0};
      end
      vecs[20] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h8888, 1'b1, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < NVec; i++) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
         chk_state($sformatf("vec%0d", i), vecs[i].dout, vecs[i].empty, vecs[i].full);
`ifdef FIFO_ERR_FLAGS_EN
         chk($sformatf("vec%0d.overflow", i), {15'd0, overflow}, {15'd0, vecs[i].ovf});
         chk($sformatf("vec%0d.underflow", i), {15'd0, underflow}, {15'd0, vecs[i].unf});
`endif
      end

      // Occupancy 4, then 10 simultaneous read+write cycles: pointers wrap past 7.
      step(1'b1, 1'b0, 1'b0, 16'h0);
      model.delete();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'hA000 + 16'(i));
         model.push_back(16'hA000 + 16'(i));
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b1, 16'hB000 + 16'(i));
         exp_word = model.pop_front();
         model.push_back(16'hB000 + 16'(i));
         chk_state($sformatf("simul%0d", i), exp_word, 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, 16'h0);
         exp_word = model.pop_front();
         chk_state($sformatf("simul_drain%0d", i), exp_word, (i == 3), 1'b0);
      end

      // Full FIFO with simultaneous read+write: both accepted, stays full.
      step(1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'hC000 + 16'(i));
      end
      step(1'b0, 1'b1, 1'b1, 16'h5555);
      chk_state("full_rw", 16'hC000, 1'b0, 1'b1);
      for (int i = 1; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b1, 16'h0);
         chk({"full_rw_drain", $sformatf("%0d", i)}, dout, 16'hC000 + 16'(i));
      end
      step(1'b0, 1'b0, 1'b1, 16'h0);
      chk_state("full_rw_last", 16'h5555, 1'b1, 1'b0);

      // Empty FIFO with simultaneous read+write: only the write is taken.
      step(1'b0, 1'b1, 1'b1, 16'h7777);
      chk_state("empty_rw", 16'h5555, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h0);
      chk_state("empty_rw_read", 16'h7777, 1'b1, 1'b0);

      // Occupancy 5, then reset: everything discarded, following read rejected.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'hE000 + 16'(i));
      end
      chk_state("occ5", 16'h7777, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 16'hFFFF);
      chk_state("mid_reset", 16'h0000, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 16'h0);
      chk_state("post_reset_read", 16'h0000, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 16'h0);
      chk_state("post_reset_idle", 16'h0000, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
